// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 24-bit execute ALU, single-cycle logic/arith/shift ops plus iterative MUL built when ALU_MUL_EN is defined
module alu_exec_unit #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    // Single-cycle datapath; shifts of 24..31 fall off the top and yield 0, unknown codes yield 0
    always_comb begin
        alu_res = (Operation == OP_AND) ? (A & B) :
                  (Operation == OP_OR)  ? (A | B) :
                  (Operation == OP_ADD) ? (A + B) :
                  (Operation == OP_SUB) ? (A - B) :
                  (Operation == OP_SLT) ? {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))} :
                  (Operation == OP_XOR) ? (A ^ B) :
                  (Operation == OP_SLL) ? (A << B[4:0]) : '0;
    end
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic IDLE = 1'b0;
    localparam logic MUL  = 1'b1;
    logic             state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_sum;
    logic [4:0]       count_q, count_d;
    // Control: accept Start only in IDLE; MUL runs exactly WIDTH shift-add steps regardless of operands
    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        if (state_q == MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 5'd1;
            if (count_q == 5'(WIDTH - 1)) begin
                state_d  = IDLE;
                count_d  = '0;
                result_d = acc_sum;
                zero_d   = (acc_sum == '0);
                done_d   = 1'b1;
            end
        end else if (Start) begin
            if (Operation == OP_MUL) begin
                state_d  = MUL;
                acc_d    = '0;
                mcand_d  = A;
                mplier_d = B;
                count_d  = '0;
            end else begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                done_d   = 1'b1;
            end
        end
    end
    // State registers; reset aborts any multiply in flight
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end
    assign Busy = (state_q == MUL);
`else
    // Without the multiplier every code, including MUL, completes in one cycle
    always_comb begin
        result_d = Start ? alu_res : result_q;
        zero_d   = Start ? (alu_res == '0) : zero_q;
        done_d   = Start;
    end
    // Output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end
    assign Busy = 1'b0;
`endif
    assign Result = result_q;
    assign Zero   = zero_q;
    assign Done   = done_q;
endmodule
